// File: rtl/or1k_bus_if_wb32.sv
// or1k_bus_if_wb32: OR1K CPU port to Wishbone B3 master bridge.
// Ports: clk, rst (async, active-low); cpu_* request side; wbm_* Wishbone master side.
module or1k_bus_if_wb32 #(
  parameter string BUS_IF_TYPE  = "CLASSIC",
  parameter int    BURST_LENGTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  input  logic        cpu_req_i,
  input  logic [3:0]  cpu_bsel_i,
  input  logic        cpu_we_i,
  input  logic        cpu_burst_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  // A one-beat burst is just a classic cycle, so it never builds state.
  localparam bit BURST_EN =
    (BUS_IF_TYPE == "B3_READ_BURSTING") && (BURST_LENGTH > 1);

  assign cpu_dat_o = wbm_dat_i;
  assign cpu_ack_o = wbm_ack_i;
  assign cpu_err_o = wbm_err_i;
  assign wbm_dat_o = cpu_dat_i;
  assign wbm_sel_o = cpu_bsel_i;
  assign wbm_we_o  = cpu_we_i;
  assign wbm_cyc_o = cpu_req_i;
  assign wbm_stb_o = cpu_req_i;

  logic unused_rty;
  assign unused_rty = wbm_rty_i;

  if (!BURST_EN) begin : g_classic
    logic unused_cls;
    assign unused_cls = ^{clk, rst, cpu_burst_i};
    assign wbm_adr_o  = cpu_adr_i;
    assign wbm_cti_o  = 3'b000;
    assign wbm_bte_o  = 2'b00;
  end else begin : g_burst
    localparam int AW = $clog2(BURST_LENGTH);
    localparam logic [AW-1:0] LAST = AW'(BURST_LENGTH - 1);
    localparam logic [1:0] BTE =
      (BURST_LENGTH == 4)  ? 2'b01 :
      (BURST_LENGTH == 8)  ? 2'b10 :
      (BURST_LENGTH == 16) ? 2'b11 : 2'b00;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wrap_q, wrap_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] cur_wrap, cur_cnt;
    logic          start, active;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        wrap_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        wrap_q  <= wrap_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      wbm_adr_o = cpu_adr_i;
      wbm_cti_o = 3'b000;
      wbm_bte_o = 2'b00;
      state_d   = IDLE;
      wrap_d    = '0;
      cnt_d     = '0;
      // Gated by rst so the outputs show idle values while held in reset.
      start = rst && (state_q == IDLE) && cpu_req_i
              && cpu_burst_i && !cpu_we_i;
      active = cpu_req_i && ((state_q == BURST) || start);
      // First beat is served straight from the request, before any state.
      cur_wrap = (state_q == BURST) ? wrap_q : cpu_adr_i[AW+1:2];
      cur_cnt  = (state_q == BURST) ? cnt_q : LAST;
      if (active) begin
        wbm_adr_o = {cpu_adr_i[31:AW+2], cur_wrap, 2'b00};
        wbm_cti_o = (cur_cnt == '0) ? 3'b111 : 3'b010;
        wbm_bte_o = BTE;
        if (wbm_err_i) begin
          state_d = IDLE;
        end else if (wbm_ack_i) begin
          if (cur_cnt != '0) begin
            state_d = BURST;
            wrap_d  = cur_wrap + 1'b1;
            cnt_d   = cur_cnt - 1'b1;
          end
        end else begin
          state_d = BURST;
          wrap_d  = cur_wrap;
          cnt_d   = cur_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_or1k_bus_if_wb32.sv
// tb_or1k_bus_if_wb32: randomized bench for or1k_bus_if_wb32.
// Classic, BL=8 and BL=4 bursting instances share one stimulus set.
module tb_or1k_bus_if_wb32;

  logic        clk, rst;
  logic [31:0] adr, dat, wdat;
  logic        req, we, burst, ack, err, rty;
  logic [3:0]  bsel;

  logic [31:0] c_cdat, c_adr, c_wdat, e_cdat, e_adr, e_wdat;
  logic [31:0] f_cdat, f_adr, f_wdat;
  logic        c_ack, c_err, c_we, c_cyc, c_stb;
  logic        e_ack, e_err, e_we, e_cyc, e_stb;
  logic        f_ack, f_err, f_we, f_cyc, f_stb;
  logic [3:0]  c_sel, e_sel, f_sel;
  logic [2:0]  c_cti, e_cti, f_cti;
  logic [1:0]  c_bte, e_bte, f_bte;

  int checks = 0;
  int failures = 0;

  or1k_bus_if_wb32 u_cls (
    .clk(clk), .rst(rst), .cpu_adr_i(adr), .cpu_dat_i(dat),
    .cpu_req_i(req), .cpu_bsel_i(bsel), .cpu_we_i(we),
    .cpu_burst_i(burst), .cpu_dat_o(c_cdat), .cpu_ack_o(c_ack),
    .cpu_err_o(c_err), .wbm_adr_o(c_adr), .wbm_dat_o(c_wdat),
    .wbm_sel_o(c_sel), .wbm_we_o(c_we), .wbm_cyc_o(c_cyc),
    .wbm_stb_o(c_stb), .wbm_cti_o(c_cti), .wbm_bte_o(c_bte),
    .wbm_dat_i(wdat), .wbm_ack_i(ack), .wbm_err_i(err),
    .wbm_rty_i(rty));

  or1k_bus_if_wb32 #(.BUS_IF_TYPE("B3_READ_BURSTING"), .BURST_LENGTH(8))
  u_b8 (
    .clk(clk), .rst(rst), .cpu_adr_i(adr), .cpu_dat_i(dat),
    .cpu_req_i(req), .cpu_bsel_i(bsel), .cpu_we_i(we),
    .cpu_burst_i(burst), .cpu_dat_o(e_cdat), .cpu_ack_o(e_ack),
    .cpu_err_o(e_err), .wbm_adr_o(e_adr), .wbm_dat_o(e_wdat),
    .wbm_sel_o(e_sel), .wbm_we_o(e_we), .wbm_cyc_o(e_cyc),
    .wbm_stb_o(e_stb), .wbm_cti_o(e_cti), .wbm_bte_o(e_bte),
    .wbm_dat_i(wdat), .wbm_ack_i(ack), .wbm_err_i(err),
    .wbm_rty_i(rty));

  or1k_bus_if_wb32 #(.BUS_IF_TYPE("B3_READ_BURSTING"), .BURST_LENGTH(4))
  u_b4 (
    .clk(clk), .rst(rst), .cpu_adr_i(adr), .cpu_dat_i(dat),
    .cpu_req_i(req), .cpu_bsel_i(bsel), .cpu_we_i(we),
    .cpu_burst_i(burst), .cpu_dat_o(f_cdat), .cpu_ack_o(f_ack),
    .cpu_err_o(f_err), .wbm_adr_o(f_adr), .wbm_dat_o(f_wdat),
    .wbm_sel_o(f_sel), .wbm_we_o(f_we), .wbm_cyc_o(f_cyc),
    .wbm_stb_o(f_stb), .wbm_cti_o(f_cti), .wbm_bte_o(f_bte),
    .wbm_dat_i(wdat), .wbm_ack_i(ack), .wbm_err_i(err),
    .wbm_rty_i(rty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; we = 0; burst = 0; ack = 0; err = 0;
    rty = 0; bsel = 4'hF; adr = 0; dat = 0; wdat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  // Reference: beat k of a wrapping burst of bl words from a.
  function automatic logic [31:0] beat_adr(int bl, logic [31:0] a, int k);
    logic [31:0] m;
    m = bl * 4 - 1;
    return (a & ~m) | ((a + 32'(4 * k)) & m);
  endfunction

  function automatic logic [1:0] bte_of(int bl);
    return (bl == 4) ? 2'd1 : (bl == 8) ? 2'd2 : (bl == 16) ? 2'd3 : 2'd0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    req = 1; burst = 1; adr = 32'h1008;
    #3;
    checks++;
    if ({e_cti, e_bte, f_cti, f_bte} !== 10'd0) begin
      failures++;
      $display("FAIL reset_cti_bte got %b want 0",
               {e_cti, e_bte, f_cti, f_bte});
    end
    checks++;
    if ({e_cyc, e_stb, c_cyc, e_adr} !== {3'b111, 32'h1008}) begin
      failures++;
      $display("FAIL reset_cyc_adr got %b %h want 111 00001008",
               {e_cyc, e_stb, c_cyc}, e_adr);
    end
    tick();
    rst = 1;
    req = 0;
    tick();
  endtask

  task automatic test_classic();
    logic [31:0] a;
    do_reset();
    // Fixed write vector first, then random accesses.
    for (int i = 0; i < 25; i++) begin
      if (i == 0) begin
        adr = 32'h100; dat = 32'hDEADBEEF; bsel = 4'hF;
        we = 1; burst = 0; ack = 1; err = 0;
      end else begin
        adr = $urandom; dat = $urandom; bsel = 4'($urandom);
        we = 1'($urandom); burst = 1'($urandom);
        ack = 1'($urandom); err = 1'($urandom);
      end
      req = 1; wdat = $urandom;
      a = adr;
      @(negedge clk);
      checks++;
      if ({c_adr, c_cti, c_bte} !== {a, 5'd0}) begin
        failures++;
        $display("FAIL classic_adr[%0d] got %h/%0d/%0d want %h/0/0",
                 i, c_adr, c_cti, c_bte, a);
      end
      checks++;
      if ({c_we, c_cyc, c_stb, c_ack, c_err} !== {we, req, req, ack, err})
      begin
        failures++;
        $display("FAIL classic_ctl[%0d] got %b want %b", i,
                 {c_we, c_cyc, c_stb, c_ack, c_err},
                 {we, req, req, ack, err});
      end
      checks++;
      if ({c_wdat, c_cdat, c_sel} !== {dat, wdat, bsel}) begin
        failures++;
        $display("FAIL classic_data[%0d] got %h %h %h want %h %h %h", i,
                 c_wdat, c_cdat, c_sel, dat, wdat, bsel);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Runs one full read burst on the bl-beat instance with random waits.
  task automatic run_burst(int bl, logic [31:0] a, int minw, int maxw);
    int waits;
    logic [31:0] ga;
    logic [2:0]  gc;
    logic [1:0]  gb;
    logic        gk;
    idle_inputs();
    req = 1; burst = 1; adr = a;
    for (int k = 0; k < bl; k++) begin
      waits = $urandom_range(minw, maxw);
      for (int w = 0; w <= waits; w++) begin
        ack = (w == waits);
        wdat = $urandom;
        @(negedge clk);
        ga = (bl == 4) ? f_adr : e_adr;
        gc = (bl == 4) ? f_cti : e_cti;
        gb = (bl == 4) ? f_bte : e_bte;
        gk = (bl == 4) ? f_ack : e_ack;
        checks++;
        if (ga !== beat_adr(bl, a, k)) begin
          failures++;
          $display("FAIL burst%0d_adr beat %0d got %h want %h",
                   bl, k, ga, beat_adr(bl, a, k));
        end
        checks++;
        if ({gc, gb} !== {((k == bl - 1) ? 3'b111 : 3'b010), bte_of(bl)})
        begin
          failures++;
          $display("FAIL burst%0d_cti beat %0d got %b/%b want %b/%b",
                   bl, k, gc, gb, (k == bl - 1) ? 3'b111 : 3'b010,
                   bte_of(bl));
        end
        checks++;
        if (gk !== ack) begin
          failures++;
          $display("FAIL burst%0d_ack beat %0d got %b want %b",
                   bl, k, gk, ack);
        end
        tick();
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst8();
    do_reset();
    run_burst(8, 32'h1008, 0, 0);
    for (int i = 0; i < 3; i++)
      run_burst(8, {$urandom} & 32'hFFFF_FFFC, 0, 2);
  endtask

  task automatic test_burst4_waits();
    do_reset();
    run_burst(4, 32'h20, 1, 3);
    for (int i = 0; i < 3; i++)
      run_burst(4, {$urandom} & 32'hFFFF_FFFC, 0, 2);
  endtask

  task automatic test_err();
    logic [31:0] a;
    do_reset();
    a = {$urandom} & 32'hFFFF_FFFC;
    req = 1; burst = 1; adr = a;
    for (int k = 0; k < 3; k++) begin
      ack = (k < 2); err = (k == 2);
      @(negedge clk);
      checks++;
      if ({e_adr, e_err} !== {beat_adr(8, a, k), err}) begin
        failures++;
        $display("FAIL err_beat%0d got %h/%b want %h/%b", k, e_adr,
                 e_err, beat_adr(8, a, k), err);
      end
      tick();
    end
    idle_inputs();
    tick();
    req = 1; burst = 1; adr = 32'h40;
    @(negedge clk);
    checks++;
    if ({e_adr, e_cti, e_bte} !== {32'h40, 3'b010, 2'b10}) begin
      failures++;
      $display("FAIL err_restart got %h/%b/%b want 00000040/010/10",
               e_adr, e_cti, e_bte);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    logic [31:0] a, b;
    do_reset();
    a = {$urandom} & 32'hFFFF_FFFC;
    b = a ^ 32'h0000_0014;
    req = 1; burst = 1; adr = a; ack = 1;
    tick();
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({e_cyc, e_cti} !== 4'd0) begin
      failures++;
      $display("FAIL abort_idle got %b want 0000", {e_cyc, e_cti});
    end
    tick();
    req = 1; burst = 1; adr = b;
    @(negedge clk);
    checks++;
    if ({e_adr, e_cti} !== {b, 3'b010}) begin
      failures++;
      $display("FAIL abort_restart got %h/%b want %h/010",
               e_adr, e_cti, b);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    do_reset();
    a = ({$urandom} & 32'hFFFF_FFE0) | 32'h8;
    req = 1; burst = 1; adr = a; ack = 1;
    for (int k = 0; k < 3; k++) tick();
    ack = 0;
    @(negedge clk);
    checks++;
    if (e_adr !== beat_adr(8, a, 3)) begin
      failures++;
      $display("FAIL rstmid_pre got %h want %h", e_adr, beat_adr(8, a, 3));
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({e_adr, e_cti, e_bte} !== {a, 5'd0}) begin
      failures++;
      $display("FAIL rstmid_clear got %h/%b/%b want %h/000/00",
               e_adr, e_cti, e_bte, a);
    end
    @(posedge clk);
    #1 rst = 1;
    idle_inputs();
    tick();
    req = 1; burst = 0; adr = 32'h80;
    @(negedge clk);
    checks++;
    if ({e_adr, e_cti, e_bte} !== {32'h80, 5'd0}) begin
      failures++;
      $display("FAIL rstmid_single got %h/%b/%b want 00000080/000/00",
               e_adr, e_cti, e_bte);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_write_burst();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      adr = {$urandom} & 32'hFFFF_FFFC;
      req = 1; burst = 1; we = (i != 7); ack = 1;
      if (i == 7) burst = 0;
      @(negedge clk);
      checks++;
      if ({e_adr, e_cti, e_bte, e_we} !== {adr, 5'd0, we}) begin
        failures++;
        $display("FAIL single[%0d] got %h/%b/%b/%b want %h/000/00/%b",
                 i, e_adr, e_cti, e_bte, e_we, adr, we);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_classic();
    test_burst8();
    test_burst4_waits();
    test_err();
    test_abort();
    test_reset_mid();
    test_write_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/or1k_bus_if_wb32.md
OR1K_BUS_IF_WB32 -- requirements
Module: or1k_bus_if_wb32

Interface
REQ-001 Parameter BUS_IF_TYPE, default "CLASSIC"; selects the bus protocol: "CLASSIC" or "B3_READ_BURSTING"; any other value SHALL behave as "CLASSIC".
REQ-002 Parameter BURST_LENGTH, default 8; beats per read burst; legal values 1, 4, 8, 16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cpu_adr_i  in  32  byte address from the CPU.
REQ-006 cpu_dat_i  in  32  write data from the CPU.
REQ-007 cpu_req_i  in  1  CPU access request, held until ack or err.
REQ-008 cpu_bsel_i  in  4  byte selects.
REQ-009 cpu_we_i  in  1  write enable.
REQ-010 cpu_burst_i  in  1  CPU requests a wrapping line-fill burst.
REQ-011 cpu_dat_o  out  32  read data to the CPU.
REQ-012 cpu_ack_o  out  1  access or beat complete.
REQ-013 cpu_err_o  out  1  bus error.
REQ-014 wbm_adr_o  out  32, wbm_dat_o  out  32, wbm_sel_o  out  4, wbm_we_o  out  1, wbm_cyc_o  out  1, wbm_stb_o  out  1, wbm_cti_o  out  3, wbm_bte_o  out  2: Wishbone B3 master outputs.
REQ-015 wbm_dat_i  in  32, wbm_ack_i  in  1, wbm_err_i  in  1, wbm_rty_i  in  1: Wishbone master inputs; wbm_rty_i SHALL be ignored.

Function
REQ-016 Both modes SHALL pass through combinationally: cpu_dat_o=wbm_dat_i, cpu_ack_o=wbm_ack_i, cpu_err_o=wbm_err_i, wbm_dat_o=cpu_dat_i, wbm_sel_o=cpu_bsel_i, wbm_we_o=cpu_we_i, wbm_cyc_o=wbm_stb_o=cpu_req_i.
REQ-017 CLASSIC mode SHALL drive wbm_adr_o=cpu_adr_i, wbm_cti_o=3'b000 and wbm_bte_o=2'b00, and SHALL hold no state.
REQ-018 B3_READ_BURSTING mode SHALL keep a state flag "bursting", a wrap address field of log2(BURST_LENGTH) bits and a beat counter.
REQ-019 A burst SHALL start when the machine is idle and cpu_req_i=1, cpu_burst_i=1 and cpu_we_i=0 at the same time; wrap address = cpu_adr_i[log2(BL)+1:2], beat counter = BL-1.
REQ-020 While a burst request is active, wbm_adr_o SHALL be {cpu_adr_i[31:log2(BL)+2], wrap field, 2'b00}; on the first beat this is cpu_adr_i (combinationally, same cycle the request appears).
REQ-021 On each wbm_ack_i during a burst, the wrap field SHALL increment modulo BL (wrap-around, upper bits unchanged) and the beat counter SHALL decrement.
REQ-022 wbm_cti_o SHALL be 3'b010 for every beat except the last, 3'b111 on the last beat (beat counter = 0), and 3'b000 for non-burst accesses.
REQ-023 wbm_bte_o SHALL be 2'b01 for BL=4, 2'b10 for BL=8, 2'b11 for BL=16, and 2'b00 otherwise or when not bursting.
REQ-024 When BURST_LENGTH=1, every access SHALL be treated as a single classic cycle.
REQ-025 The machine SHALL return to idle on the ack of the last beat, on wbm_err_i=1, or when cpu_req_i drops mid-burst (abort). After an abort, the next request SHALL start a fresh burst from its own address.
REQ-026 Writes, and reads with cpu_burst_i=0, SHALL be single cycles: wbm_adr_o=cpu_adr_i, wbm_cti_o=3'b000, wbm_bte_o=2'b00.

Reset
REQ-027 While rst=0, the machine SHALL be forced idle asynchronously, with bursting, wrap field and beat counter all cleared. The outputs are then the combinational values for idle (wbm_cti_o=0, wbm_bte_o=0, wbm_cyc_o/wbm_stb_o following cpu_req_i). The machine SHALL leave reset on the first clk edge after rst=1.

Verification
REQ-028 CLASSIC, write adr 0x100, dat 0xDEADBEEF, bsel 0xF, 1-cycle ack -> wbm_adr_o=0x100, wbm_we_o=1, wbm_cti_o=0, wbm_bte_o=0, cpu_ack_o same cycle as wbm_ack_i.
REQ-029 B3_READ_BURSTING, BL=8, burst read from 0x1008, ack every cycle -> addresses 0x1008,0x100C,0x1010,0x1014,0x1018,0x101C,0x1000,0x1004; cti 010 for seven beats then 111; bte=10.
REQ-030 BL=4, burst read from 0x20 with wait states between acks -> address advances only on ack: 0x20,0x24,0x28,0x2C; bte=01; last beat cti=111.
REQ-031 BL=8, wbm_err_i on the third beat -> cpu_err_o=1 that cycle; next burst from 0x40 starts at 0x40 with cti=010.
REQ-032 BL=8, rst driven low mid-burst between clock edges -> state cleared immediately; after release, a read with cpu_burst_i=0 to 0x80 gives cti=000 and adr=0x80.
REQ-033 BL=8, cpu_burst_i=1 with cpu_we_i=1 -> single cycle, cti=000, bte=00.
